// File: rtl/musa_pkg.sv
// Shared pipeline definitions: ALU flag and control bit positions and the
// execute-to-memory entry layout.
package musa_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam int FLAG_W     = 4;
    localparam int FLAG_OVF   = 3;
    localparam int FLAG_ABOVE = 2;
    localparam int FLAG_EQ    = 1;
    localparam int FLAG_ZERO  = 0;

    localparam int CTRL_W         = 3;
    localparam int CTRL_REG_WRITE = 2;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 0;

    typedef struct packed {
        logic [XLEN-1:0]      result;
        logic [FLAG_W-1:0]    flags;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      pc;
        logic [CTRL_W-1:0]    ctrl;
    } ex_mem_entry_t;

    localparam int ENTRY_W = $bits(ex_mem_entry_t);

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry in-order FIFO with registered occupancy; outputs come only from
// flops, so there is no combinational path from push side to pop side.
module skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    always_comb begin
        push_ready = (count_q != 2'd2) && !reset;
        pop_valid  = (count_q != 2'd0);
        pop_data   = pop_valid ? mem_q[rd_ptr_q] : '0;
        push       = push_valid && push_ready;
        pop        = pop_valid && pop_ready;

        // NOTE: every _d gets a default before any branch so no latch is inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: storage is only two entries and must read as zero after reset, so it is reset too.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ex_mem_buffer.sv
// Execute-to-memory pipeline buffer: 2-entry FIFO plus overflow-trap
// handling (bubble the trapping entry, pulse exception, count traps).
module ex_mem_buffer
    import musa_pkg::*;
#(
    parameter bit TRAP_EN = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_result,
    input  logic [FLAG_W-1:0]    in_flags,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic                 in_trap_en,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [FLAG_W-1:0]    out_flags,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic [XLEN-1:0]      out_pc,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic                 exc_valid,
    output logic [XLEN-1:0]      exc_pc,
    output logic [7:0]           trap_count
);

    ex_mem_entry_t   in_entry;
    ex_mem_entry_t   head;
    logic            accept;
    logic            trap;
    logic            exc_valid_q, exc_valid_d;
    logic [XLEN-1:0] exc_pc_q, exc_pc_d;
    logic [7:0]      trap_count_q, trap_count_d;

    skid_fifo2 #(.WIDTH(ENTRY_W)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (in_entry),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head)
    );

    always_comb begin
        // A flushed push never lands, so it must not raise a trap either.
        accept = in_valid && in_ready && !flush;
        trap   = accept && in_flags[FLAG_OVF] && in_trap_en && TRAP_EN;

        in_entry.result = in_result;
        in_entry.flags  = in_flags;
        in_entry.rd     = in_rd;
        in_entry.pc     = in_pc;
        in_entry.ctrl   = trap ? '0 : in_ctrl;

        exc_valid_d  = trap;
        exc_pc_d     = trap ? in_pc : exc_pc_q;
        trap_count_d = trap ? sat_inc8(trap_count_q) : trap_count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            exc_valid_q  <= 1'b0;
            exc_pc_q     <= '0;
            trap_count_q <= 8'd0;
        end else begin
            exc_valid_q  <= exc_valid_d;
            exc_pc_q     <= exc_pc_d;
            trap_count_q <= trap_count_d;
        end
    end

    assign out_result = head.result;
    assign out_flags  = head.flags;
    assign out_rd     = head.rd;
    assign out_pc     = head.pc;
    assign out_ctrl   = head.ctrl;
    assign exc_valid  = exc_valid_q;
    assign exc_pc     = exc_pc_q;
    assign trap_count = trap_count_q;

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Directed bench for ex_mem_buffer: FIFO ordering, back-pressure, traps,
// flush, saturation and reset behaviour.
module tb_ex_mem_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_flags;
    logic [4:0]  in_rd;
    logic [31:0] in_pc;
    logic [2:0]  in_ctrl;
    logic        in_trap_en;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic [4:0]  out_rd;
    logic [31:0] out_pc;
    logic [2:0]  out_ctrl;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [7:0]  trap_count;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clock = ~clock;

    ex_mem_buffer #(.TRAP_EN(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .in_rd      (in_rd),
        .in_pc      (in_pc),
        .in_ctrl    (in_ctrl),
        .in_trap_en (in_trap_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_rd     (out_rd),
        .out_pc     (out_pc),
        .out_ctrl   (out_ctrl),
        .exc_valid  (exc_valid),
        .exc_pc     (exc_pc),
        .trap_count (trap_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] flg,
                         input logic [4:0] rd, input logic [31:0] pc, input logic [2:0] ctrl,
                         input logic ten);
        in_valid   = v;
        in_result  = res;
        in_flags   = flg;
        in_rd      = rd;
        in_pc      = pc;
        in_ctrl    = ctrl;
        in_trap_en = ten;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 3'b000, 1'b0);

        // Reset state
        tick();
        tick();
        check("rst_in_ready",   in_ready,   0);
        check("rst_out_valid",  out_valid,  0);
        check("rst_out_result", out_result, 0);
        check("rst_exc_valid",  exc_valid,  0);
        check("rst_exc_pc",     exc_pc,     0);
        check("rst_trap_count", trap_count, 0);
        reset = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);

        // Single push through an empty buffer, latency 1
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0005, 4'h0, 5'd3, 32'h0000_0100, 3'b100, 1'b0);
        tick();
        drive(1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 3'b000, 1'b0);
        check("single_valid",  out_valid,  1);
        check("single_result", out_result, 32'h5);
        check("single_rd",     out_rd,     3);
        check("single_ctrl",   out_ctrl,   3'b100);
        check("single_pc",     out_pc,     32'h100);
        tick();
        check("single_empty",  out_valid,  0);
        check("single_zero",   out_result, 0);

        // Back-pressure: third push refused, order preserved
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 4'h1, 5'd1, 32'h200, 3'b100, 1'b0);
        tick();
        drive(1'b1, 32'h22, 4'h2, 5'd2, 32'h204, 3'b010, 1'b0);
        check("bp_ready_1", in_ready, 1);
        tick();
        drive(1'b1, 32'h33, 4'h4, 5'd4, 32'h208, 3'b001, 1'b0);
        check("bp_ready_full", in_ready, 0);
        tick();
        drive(1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 3'b000, 1'b0);
        check("bp_hold_a", out_result, 32'h11);
        tick();
        check("bp_stable_a", out_result, 32'h11);
        check("bp_stable_rd", out_rd, 1);
        out_ready = 1'b1;
        tick();
        check("bp_second_b", out_result, 32'h22);
        check("bp_second_ctrl", out_ctrl, 3'b010);
        tick();
        check("bp_drained", out_valid, 0);

        // Trapping overflow entry becomes a bubble
        out_ready = 1'b0;
        drive(1'b1, 32'h7FFF_FFFF, 4'b1000, 5'd7, 32'h0040_0010, 3'b110, 1'b1);
        tick();
        drive(1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 3'b000, 1'b0);
        check("trap_out_valid", out_valid, 1);
        check("trap_out_ctrl",  out_ctrl,  3'b000);
        check("trap_out_flags", out_flags, 4'b1000);
        check("trap_exc_valid", exc_valid, 1);
        check("trap_exc_pc",    exc_pc,    32'h0040_0010);
        check("trap_count_1",   trap_count, 1);
        tick();
        check("trap_pulse_end", exc_valid, 0);
        check("trap_pc_held",   exc_pc,    32'h0040_0010);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flush of a full buffer with a same-cycle push
        drive(1'b1, 32'hA1, 4'h0, 5'd1, 32'h300, 3'b100, 1'b0);
        tick();
        drive(1'b1, 32'hA2, 4'h0, 5'd2, 32'h304, 3'b100, 1'b0);
        tick();
        check("flush_full", in_ready, 0);
        flush = 1'b1;
        drive(1'b1, 32'hA3, 4'b1000, 5'd3, 32'h308, 3'b100, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 3'b000, 1'b0);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready",  in_ready,  1);
        check("flush_no_exc",    exc_valid, 0);
        check("flush_count_kept", trap_count, 1);
        check("flush_pc_kept",    exc_pc, 32'h0040_0010);

        // Flush with one entry held and an acceptable trapping push
        drive(1'b1, 32'hB1, 4'h0, 5'd1, 32'h400, 3'b100, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'hB2, 4'b1000, 5'd2, 32'h404, 3'b100, 1'b1);
        check("flush1_ready", in_ready, 1);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 3'b000, 1'b0);
        check("flush1_out_valid", out_valid, 0);
        check("flush1_no_exc",    exc_valid, 0);
        check("flush1_count",     trap_count, 1);
        tick();
        check("flush1_still_empty", out_valid, 0);

        // 300 trapping entries streamed: count saturates
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, i, 4'b1000, 5'd9, 32'h1000 + 32'(i) * 4, 3'b100, 1'b1);
            tick();
            if (i == 99) begin
                check("sat_mid_count", trap_count, 101);
                check("sat_mid_exc",   exc_valid,  1);
            end
        end
        drive(1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 3'b000, 1'b0);
        check("sat_count_255", trap_count, 255);
        check("sat_last_pc",   exc_pc,     32'h0000_14AC);
        check("sat_last_ctrl", out_ctrl,   3'b000);
        tick();
        check("sat_drained",   out_valid,  0);
        check("sat_held_255",  trap_count, 255);

        // Overflow without trap enable passes through unmodified
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_0000, 4'b1000, 5'd5, 32'h0000_5000, 3'b101, 1'b0);
        tick();
        drive(1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 3'b000, 1'b0);
        check("notrap_ctrl",  out_ctrl,   3'b101);
        check("notrap_flags", out_flags,  4'b1000);
        check("notrap_exc",   exc_valid,  0);
        check("notrap_count", trap_count, 255);
        check("notrap_pc",    exc_pc,     32'h0000_14AC);

        // Reset with two entries held and a trapping push pending
        drive(1'b1, 32'hC2, 4'h0, 5'd2, 32'h604, 3'b100, 1'b0);
        tick();
        check("mid_full", in_ready, 0);
        reset = 1'b1;
        drive(1'b1, 32'hC3, 4'b1000, 5'd3, 32'h608, 3'b100, 1'b1);
        #1;
        check("mid_rst_ready_comb", in_ready, 0);
        tick();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready",  in_ready,  0);
        check("mid_rst_result",    out_result, 0);
        check("mid_rst_count",     trap_count, 0);
        tick();
        check("mid_rst_no_exc",    exc_valid, 0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 3'b000, 1'b0);
        #1;
        check("mid_rel_ready", in_ready, 1);
        tick();
        check("mid_rel_empty", out_valid, 0);
        check("mid_rel_exc",   exc_valid, 0);
        check("mid_rel_pc",    exc_pc,    0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
